chameleon_spi_flash_writer: RTL

- Programs a byte range from an on-chip source buffer into the SPI NOR flash.
- It is the write-direction counterpart of the flash loader.
- Sits between a buffer-side fetch handshake (request address, receive byte) and the shared byte-level SPI master (toggle req/ack), and drives flash chip-select directly.
- Splits the range into page-program commands on 256-byte flash page boundaries and polls the status register after each page.

---
 rtl/chameleon_spi_flash_writer.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/chameleon_spi_flash_writer.sv
// Programs a source-buffer byte range into SPI NOR flash, page by page, polling status after each page.
// Optional sector erase before each 4 KB sector: define CHAMELEON_SPI_FLASH_WRITER_ERASE_EN.
module chameleon_spi_flash_writer #(
  parameter int unsigned a_bits     = 14,
  parameter int unsigned poll_limit = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        slot,
  input  logic              start,
  input  logic [a_bits-1:0] start_addr,
  input  logic [19:0]       flash_offset,
  input  logic [15:0]       amount,
  output logic              busy,
  output logic              error,
  output logic              cs_n,
  output logic              spi_req,
  input  logic              spi_ack,
  output logic [7:0]        spi_d,
  input  logic [7:0]        spi_q,
  output logic              req,
  input  logic              ack,
  output logic [a_bits-1:0] a,
  input  logic [7:0]        q
);

  localparam int unsigned pc_w = (poll_limit > 1) ? $clog2(poll_limit) : 1;

`ifdef CHAMELEON_SPI_FLASH_WRITER_ERASE_EN
  localparam bit erase_en = 1'b1;
`else
  localparam bit erase_en = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_GAP, S_CS_ON, S_WREN, S_ER_CMD, S_ER_ADDR, S_PP_CMD,
    S_PP_ADDR, S_FETCH, S_PP_DATA, S_SR_CMD, S_SR_POLL, S_NEXT
  } state_t;

  state_t            state;
  state_t            resume;
  logic [1:0]        idx;
  logic              spi_pend;
  logic              fetch_pend;
  logic [a_bits-1:0] src;
  logic [23:0]       fa;
  logic [15:0]       cnt;
  logic [7:0]        data;
  logic [pc_w-1:0]   poll_cnt;
  logic              er_phase;

  logic              spi_done_c;
  logic              fetch_done_c;
  logic              spi_state_c;
  logic [7:0]        tx_byte_c;
  logic [7:0]        pp_byte_c;
  logic [7:0]        er_byte_c;
  logic              unused_spi_q_c;

  assign spi_done_c     = spi_pend && (spi_ack == spi_req);
  assign fetch_done_c   = fetch_pend && (ack == req);
  assign unused_spi_q_c = ^spi_q[7:1];

  // Address bytes, MSB first; erase addresses are 4 KB aligned
  assign pp_byte_c = (idx == 2'd0) ? fa[23:16] : (idx == 2'd1) ? fa[15:8] : fa[7:0];
  assign er_byte_c = (idx == 2'd0) ? fa[23:16] : (idx == 2'd1) ? {fa[15:12], 4'h0} : 8'h00;

  // Byte shifted out by each SPI-issuing state
  always_comb begin
    spi_state_c = 1'b1;
    tx_byte_c   = 8'h00;
    case (state)
      S_WREN:    tx_byte_c = 8'h06;
      S_ER_CMD:  tx_byte_c = 8'h20;
      S_ER_ADDR: tx_byte_c = er_byte_c;
      S_PP_CMD:  tx_byte_c = 8'h02;
      S_PP_ADDR: tx_byte_c = pp_byte_c;
      S_PP_DATA: tx_byte_c = data;
      S_SR_CMD:  tx_byte_c = 8'h05;
      S_SR_POLL: tx_byte_c = 8'hFF;
      default:   spi_state_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      resume     <= S_IDLE;
      busy       <= 1'b0;
      error      <= 1'b0;
      cs_n       <= 1'b1;
      spi_req    <= 1'b0;
      spi_d      <= 8'h00;
      req        <= 1'b0;
      a          <= '0;
      idx        <= 2'd0;
      spi_pend   <= 1'b0;
      fetch_pend <= 1'b0;
      src        <= '0;
      fa         <= 24'h000000;
      cnt        <= 16'h0000;
      data       <= 8'h00;
      poll_cnt   <= '0;
      er_phase   <= 1'b0;
    end else begin
      // Launch one SPI byte on entry to any byte state; the case below reacts to its ack
      if (spi_state_c && !spi_pend) begin
        spi_d    <= tx_byte_c;
        spi_req  <= ~spi_req;
        spi_pend <= 1'b1;
      end
      if (spi_done_c) spi_pend <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            src   <= start_addr;
            fa    <= {slot, flash_offset};
            cnt   <= amount;
            error <= 1'b0;
            if (amount != 16'h0000) begin
              busy     <= 1'b1;
              er_phase <= erase_en;
              resume   <= S_WREN;
              state    <= S_CS_ON;
            end
          end
        end
        S_GAP: state <= S_CS_ON;
        S_CS_ON: begin
          cs_n  <= 1'b0;
          state <= resume;
        end
        S_WREN: begin
          if (spi_done_c) begin
            cs_n   <= 1'b1;
            resume <= er_phase ? S_ER_CMD : S_PP_CMD;
            state  <= S_GAP;
          end
        end
        S_ER_CMD: begin
          if (spi_done_c) begin
            idx   <= 2'd0;
            state <= S_ER_ADDR;
          end
        end
        S_ER_ADDR: begin
          if (spi_done_c) begin
            if (idx == 2'd2) begin
              cs_n   <= 1'b1;
              resume <= S_SR_CMD;
              state  <= S_GAP;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        S_PP_CMD: begin
          if (spi_done_c) begin
            idx   <= 2'd0;
            state <= S_PP_ADDR;
          end
        end
        S_PP_ADDR: begin
          if (spi_done_c) begin
            if (idx == 2'd2) state <= S_FETCH;
            else             idx   <= idx + 2'd1;
          end
        end
        S_FETCH: begin
          if (!fetch_pend) begin
            a          <= src;
            req        <= ~req;
            fetch_pend <= 1'b1;
          end else if (fetch_done_c) begin
            data       <= q;
            fetch_pend <= 1'b0;
            state      <= S_PP_DATA;
          end
        end
        S_PP_DATA: begin
          if (spi_done_c) begin
            src <= src + a_bits'(1);
            fa  <= fa + 24'd1;
            cnt <= cnt - 16'd1;
            // Page ends on the last byte or when the low address byte wraps
            if (cnt == 16'd1 || fa[7:0] == 8'hFF) begin
              cs_n   <= 1'b1;
              resume <= S_SR_CMD;
              state  <= S_GAP;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_SR_CMD: begin
          if (spi_done_c) begin
            poll_cnt <= '0;
            state    <= S_SR_POLL;
          end
        end
        S_SR_POLL: begin
          if (spi_done_c) begin
            if (!spi_q[0]) begin
              cs_n  <= 1'b1;
              state <= S_NEXT;
            end else if (poll_cnt == pc_w'(poll_limit - 1)) begin
              cs_n  <= 1'b1;
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              poll_cnt <= poll_cnt + pc_w'(1);
            end
          end
        end
        S_NEXT: begin
          if (er_phase) begin
            er_phase <= 1'b0;
            resume   <= S_WREN;
            state    <= S_CS_ON;
          end else if (cnt == 16'h0000) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            er_phase <= erase_en && (fa[11:0] == 12'h000);
            resume   <= S_WREN;
            state    <= S_CS_ON;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
